decode_queue_ctrl: RTL



---
 rtl/decode_queue_pkg.sv | 13 +
 rtl/decode_queue_mem.sv | 28 ++
 rtl/decode_queue_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/decode_queue_pkg.sv
// Shared width helpers for the decode-stage queue controller.
// Imported by the queue top and its storage array.
package decode_queue_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/decode_queue_mem.sv
// DEPTH x WIDTH payload array for the decode queue.
// Synchronous write, combinational read of the head slot.
module decode_queue_mem
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/decode_queue_ctrl.sv
// Decode-stage flow controller: DEPTH-entry payload queue with RAW
// stall, flush, one-shot branch-resolved pulse and stall counter.
module decode_queue_ctrl
  import decode_queue_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int WIDTH     = 32,
  parameter bit FULL_PASS = 1'b0,
  parameter int STALL_W   = 16,
  localparam int CNT_W    = cnt_w(DEPTH),
  localparam int PTR_W    = ptr_w(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid_pre_i,
  output logic               ready_pre_o,
  input  logic [WIDTH-1:0]   data_i,
  output logic               valid_post_o,
  input  logic               ready_post_i,
  output logic [WIDTH-1:0]   data_o,
  input  logic               raw_i,
  input  logic               flush_i,
  output logic               branch_valid_o,
  output logic [CNT_W-1:0]   count_o,
  output logic [STALL_W-1:0] stall_cnt_o
);

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_reported;
  logic [STALL_W-1:0] r_stall;

  logic               w_full;
  logic               w_nempty;
  logic               w_push;
  logic               w_pop;
  logic               w_stall;
  logic [PTR_W-1:0]   w_wr_nxt;
  logic [PTR_W-1:0]   w_rd_nxt;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_nempty = (r_count != '0);

  assign valid_post_o = w_nempty && !raw_i && !flush_i;
  assign w_pop        = valid_post_o && ready_post_i;

  // FULL_PASS lets a same-cycle pop make room for the incoming push
  assign ready_pre_o = !flush_i &&
                       (!w_full || (FULL_PASS && w_pop));
  assign w_push      = valid_pre_i && ready_pre_o;

  assign branch_valid_o = valid_post_o && !r_reported;
  assign w_stall        = w_nempty && raw_i && !flush_i;

  assign w_wr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ?
                    '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ?
                    '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_reported <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_pop) begin
        r_reported <= 1'b0;
      end else if (branch_valid_o) begin
        r_reported <= 1'b1;
      end
    end
  end

  // flush leaves the stall statistic intact
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != {STALL_W{1'b1}})) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  decode_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clock   (clock),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_i),
    .i_raddr (r_rd_ptr),
    .o_rdata (data_o)
  );

  assign count_o     = r_count;
  assign stall_cnt_o = r_stall;

endmodule
